// File: rtl/spi_job_sched_if.sv
// Requester job port plus APB master port between spi_job_sched and its surroundings.
interface spi_job_sched_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_addr;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   done;
  logic                 err;
  logic                 busy;
  logic [7:0]           paddr;
  logic [7:0]           pwdata;
  logic                 pwrite;
  logic                 penable;
  logic [7:0]           prdata;
  logic                 pready;

  modport master (
    input  req, req_addr, req_data, prdata, pready,
    output gnt, done, err, busy, paddr, pwdata, pwrite, penable
  );

  modport slave (
    output req, req_addr, req_data, prdata, pready,
    input  gnt, done, err, busy, paddr, pwdata, pwrite, penable
  );
endinterface

// File: rtl/spi_job_sched.sv
// Round-robin job scheduler driving spi_ctrl over APB: addr/data/ctrl writes, then ctrl polling.
// APB access phases stretch on pready low; a per-job cycle budget aborts stalled or stuck jobs.
module spi_job_sched #(
  parameter int NUM_REQ  = 4,
  parameter int POLL_GAP = 16,
  parameter int TIMEOUT  = 4096
) (
  input  logic            pclk_i,
  input  logic            prst_i,
  spi_job_sched_if.master bus
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GW = $clog2(POLL_GAP + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA, S_WR_CTRL, S_POLL_WAIT, S_POLL_RD, S_DONE
  } state_t;

  state_t             state;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] done;
  logic               err;
  logic               busy;
  logic [7:0]         paddr;
  logic [7:0]         pwdata;
  logic               pwrite;
  logic               penable;
  logic [2:0]         slot_ptr;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      cur;
  logic [7:0]         addr_q;
  logic [7:0]         data_q;
  logic [12:0]        tmo_cnt;
  logic [GW-1:0]      gap_cnt;
  logic               pick_vld;
  logic [IW-1:0]      pick_idx;
  logic               unused_rd;

  assign unused_rd = ^bus.prdata[7:1];

  // First requesting index at or after rr_ptr, wrapping.
  always_comb begin : pick_blk
    int j;
    j        = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!pick_vld && bus.req[j]) begin
        pick_vld = 1'b1;
        pick_idx = IW'(j);
      end
    end
  end

  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      state    <= S_IDLE;
      gnt      <= '0;
      done     <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
      paddr    <= '0;
      pwdata   <= '0;
      pwrite   <= 1'b0;
      penable  <= 1'b0;
      slot_ptr <= '0;
      rr_ptr   <= '0;
      cur      <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      tmo_cnt  <= '0;
      gap_cnt  <= '0;
    end else begin
      done <= '0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            cur     <= pick_idx;
            addr_q  <= bus.req_addr[{pick_idx, 3'b000} +: 8];
            data_q  <= bus.req_data[{pick_idx, 3'b000} +: 8];
            gnt     <= NUM_REQ'(1) << pick_idx;
            busy    <= 1'b1;
            tmo_cnt <= 13'd1;
            paddr   <= {5'd0, slot_ptr};
            pwdata  <= bus.req_addr[{pick_idx, 3'b000} +: 8];
            pwrite  <= 1'b1;
            state   <= S_WR_ADDR;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
          rr_ptr <= (cur == IW'(NUM_REQ - 1)) ? '0 : cur + 1'b1;
          // After an abort spi_ctrl's index did not move, so neither does ours.
          if (!err) slot_ptr <= slot_ptr + 3'd1;
        end
        default: begin
          tmo_cnt <= tmo_cnt + 13'd1;
          if (tmo_cnt == 13'(TIMEOUT)) begin
            penable <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
            pwrite  <= 1'b0;
            done    <= gnt;
            gnt     <= '0;
            err     <= 1'b1;
            state   <= S_DONE;
          end else begin
            case (state)
              S_WR_ADDR: begin
                if (!penable) penable <= 1'b1;
                else if (bus.pready) begin
                  penable <= 1'b0;
                  paddr   <= 8'h10 + {5'd0, slot_ptr};
                  pwdata  <= data_q;
                  state   <= S_WR_DATA;
                end
              end
              S_WR_DATA: begin
                if (!penable) penable <= 1'b1;
                else if (bus.pready) begin
                  penable <= 1'b0;
                  paddr   <= 8'h20;
                  pwdata  <= 8'h01;
                  state   <= S_WR_CTRL;
                end
              end
              S_WR_CTRL: begin
                if (!penable) penable <= 1'b1;
                else if (bus.pready) begin
                  penable <= 1'b0;
                  paddr   <= '0;
                  pwdata  <= '0;
                  pwrite  <= 1'b0;
                  gap_cnt <= '0;
                  state   <= S_POLL_WAIT;
                end
              end
              S_POLL_WAIT: begin
                if (gap_cnt == GW'(POLL_GAP - 1)) begin
                  paddr  <= 8'h20;
                  pwdata <= '0;
                  pwrite <= 1'b0;
                  state  <= S_POLL_RD;
                end else begin
                  gap_cnt <= gap_cnt + 1'b1;
                end
              end
              S_POLL_RD: begin
                if (!penable) penable <= 1'b1;
                else if (bus.pready) begin
                  penable <= 1'b0;
                  paddr   <= '0;
                  if (!bus.prdata[0]) begin
                    done  <= gnt;
                    gnt   <= '0;
                    state <= S_DONE;
                  end else begin
                    gap_cnt <= '0;
                    state   <= S_POLL_WAIT;
                  end
                end
              end
              default: state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign bus.gnt     = gnt;
  assign bus.done    = done;
  assign bus.err     = err;
  assign bus.busy    = busy;
  assign bus.paddr   = paddr;
  assign bus.pwdata  = pwdata;
  assign bus.pwrite  = pwrite;
  assign bus.penable = penable;

endmodule

// File: tb/tb_spi_job_sched.sv
// Directed bench for spi_job_sched with a small APB slave/monitor and hand-computed expectations.
module tb_spi_job_sched;
  logic pclk;
  logic prst;

  spi_job_sched_if #(.NUM_REQ(4)) ifc ();

  spi_job_sched #(.NUM_REQ(4), .POLL_GAP(4), .TIMEOUT(256)) dut (
    .pclk_i(pclk),
    .prst_i(prst),
    .bus   (ifc)
  );

  int total = 0;
  int bad   = 0;

  int   cyc = 0, done_cnt = 0, ctrl_cnt = 0, rd_cnt = 0, acc_cyc = 0;
  int   busy_polls = 0, ready_lat = 1;
  logic stall_en = 1'b0;
  int   gnt_cyc = 0, done_cyc = 0;
  logic [3:0] prev_gnt = '0, last_done = '0;
  logic last_err = 1'b0, pen_before = 1'b0, pen_at = 1'b0, prev_pen = 1'b0;
  logic [16:0] txn_q[$];
  logic [3:0]  gnt_q[$];
  logic [7:0]  slot_q[$];

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  initial forever begin
    @(posedge pclk);
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // APB slave responder and transaction monitor, both on the falling edge.
  initial begin
    ifc.pready = 1'b0;
    ifc.prdata = 8'h00;
    forever begin
      @(negedge pclk);
      if (ifc.penable && !(stall_en && ifc.paddr[7:4] == 4'h1)) begin
        ifc.pready = (acc_cyc >= ready_lat);
        acc_cyc++;
      end else begin
        ifc.pready = 1'b0;
        acc_cyc = 0;
      end
      ifc.prdata = (ifc.penable && !ifc.pwrite && rd_cnt < busy_polls) ? 8'h01 : 8'h00;
      if (ifc.penable && ifc.pready) begin
        txn_q.push_back({ifc.pwrite, ifc.paddr, ifc.pwdata});
        if (ifc.pwrite && ifc.paddr < 8'h08) slot_q.push_back(ifc.paddr);
        if (ifc.pwrite && ifc.paddr == 8'h20) ctrl_cnt++;
        if (!ifc.pwrite) rd_cnt++;
      end
      if (ifc.gnt != 4'b0 && prev_gnt == 4'b0) begin
        gnt_q.push_back(ifc.gnt);
        gnt_cyc = cyc;
      end
      prev_gnt = ifc.gnt;
      if (ifc.done != 4'b0) begin
        done_cnt++;
        last_done  = ifc.done;
        last_err   = ifc.err;
        done_cyc   = cyc;
        pen_before = prev_pen;
        pen_at     = ifc.penable;
        rd_cnt     = 0;
      end
      prev_pen = ifc.penable;
    end
  end

  task automatic step();
    @(negedge pclk);
    #1;
  endtask

  task automatic wait_done(input int n);
    int k;
    k = 0;
    while (done_cnt < n && k < 3000) begin
      step();
      k++;
    end
    chk("done_wait", 32'(done_cnt >= n), 32'd1);
  endtask

  task automatic wait_gnt(input int n);
    int k;
    k = 0;
    while (gnt_q.size() < n && k < 200) begin
      step();
      k++;
    end
    chk("gnt_wait", 32'(gnt_q.size() >= n), 32'd1);
  endtask

  // Post one job and drop the request as soon as it is granted.
  task automatic one_job(input logic [3:0] r);
    int g0, d0;
    g0 = gnt_q.size();
    d0 = done_cnt;
    ifc.req = r;
    wait_gnt(g0 + 1);
    ifc.req = 4'b0;
    wait_done(d0 + 1);
  endtask

  task automatic do_reset();
    prst = 1'b1;
    step();
    step();
    chk("rst_outs", {ifc.gnt, ifc.done, ifc.err, ifc.busy, ifc.penable, ifc.pwrite},
        32'd0);
    chk("rst_bus", {ifc.paddr, ifc.pwdata}, 32'd0);
    prst = 1'b0;
    step();
  endtask

  initial begin
    int t0, g0, s0, d0;
    logic [16:0] exp_txn[5];
    prst = 1'b1;
    ifc.req = 4'b0;
    ifc.req_addr = '0;
    ifc.req_data = '0;
    step();
    do_reset();

    // Basic job: three writes, two polls; inputs change after grant but latched values used.
    ifc.req_addr = {8'h11, 8'h22, 8'h33, 8'h85};
    ifc.req_data = {8'h44, 8'h55, 8'h66, 8'h3C};
    ready_lat  = 1;
    busy_polls = 1;
    t0 = txn_q.size();
    ifc.req = 4'b0001;
    wait_gnt(1);
    ifc.req = 4'b0;
    ifc.req_addr[7:0] = 8'hFF;
    ifc.req_data[7:0] = 8'hFF;
    chk("t1_busy", 32'(ifc.busy), 32'd1);
    chk("t1_gnt", 32'(ifc.gnt), 32'h1);
    wait_done(1);
    chk("t1_done", 32'(last_done), 32'h1);
    chk("t1_err", 32'(last_err), 32'd0);
    chk("t1_ntxn", 32'(txn_q.size() - t0), 32'd5);
    exp_txn[0] = {1'b1, 8'h00, 8'h85};
    exp_txn[1] = {1'b1, 8'h10, 8'h3C};
    exp_txn[2] = {1'b1, 8'h20, 8'h01};
    exp_txn[3] = {1'b0, 8'h20, 8'h00};
    exp_txn[4] = {1'b0, 8'h20, 8'h00};
    for (int i = 0; i < 5; i++)
      if (t0 + i < txn_q.size()) chk($sformatf("t1_txn%0d", i), 32'(txn_q[t0 + i]), 32'(exp_txn[i]));
    step();
    chk("t1_idle_busy", 32'(ifc.busy), 32'd0);

    // Round robin across all requesters and slot wrap over nine jobs.
    ifc.req_addr = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    ifc.req_data = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    do_reset();
    ready_lat  = 0;
    busy_polls = 0;
    g0 = gnt_q.size();
    s0 = slot_q.size();
    d0 = done_cnt;
    ifc.req = 4'b1111;
    wait_done(d0 + 9);
    ifc.req = 4'b0;
    for (int j = 0; j < 9; j++) begin
      if (g0 + j < gnt_q.size()) chk($sformatf("t2_gnt%0d", j), 32'(gnt_q[g0 + j]), 32'(4'b0001 << (j % 4)));
      if (s0 + j < slot_q.size()) chk($sformatf("t2_slot%0d", j), 32'(slot_q[s0 + j]), 32'(j % 8));
    end
    step();
    step();

    // Serve requester 2 alone, then 0 and 2 together: 0 must win.
    one_job(4'b0100);
    chk("t3_first", 32'(gnt_q[gnt_q.size() - 1]), 32'b0100);
    one_job(4'b0101);
    chk("t3_rr", 32'(gnt_q[gnt_q.size() - 1]), 32'b0001);
    chk("t3_slot", 32'(slot_q[slot_q.size() - 1]), 32'd2);

    // Ctrl never reports completion: abort after the cycle budget, slot reused.
    busy_polls = 100000;
    one_job(4'b0010);
    chk("t4_done", 32'(last_done), 32'b0010);
    chk("t4_err", 32'(last_err), 32'd1);
    chk("t4_lat", 32'(done_cyc - gnt_cyc), 32'd256);
    busy_polls = 0;
    step();
    one_job(4'b1000);
    chk("t4_reslot", 32'(slot_q[slot_q.size() - 1]), 32'd3);
    chk("t4_next_err", 32'(last_err), 32'd0);

    // Data write stalls in its access phase until the budget runs out.
    stall_en = 1'b1;
    one_job(4'b0001);
    stall_en = 1'b0;
    chk("t5_err", 32'(last_err), 32'd1);
    chk("t5_pen_held", 32'(pen_before), 32'd1);
    chk("t5_pen_drop", 32'(pen_at), 32'd0);
    chk("t5_lat", 32'(done_cyc - gnt_cyc), 32'd256);
    chk("t5_slot", 32'(slot_q[slot_q.size() - 1]), 32'd4);

    // Reset while waiting between polls abandons the job.
    busy_polls = 100000;
    t0 = ctrl_cnt;
    g0 = gnt_q.size();
    ifc.req = 4'b0100;
    wait_gnt(g0 + 1);
    ifc.req = 4'b0;
    for (int k = 0; k < 100 && ctrl_cnt == t0; k++) step();
    chk("t6_ctrl_seen", 32'(ctrl_cnt), 32'(t0 + 1));
    step();
    d0 = done_cnt;
    prst = 1'b1;
    step();
    chk("t6_rst_outs", {ifc.gnt, ifc.done, ifc.err, ifc.busy, ifc.penable, ifc.pwrite}, 32'd0);
    chk("t6_rst_bus", {ifc.paddr, ifc.pwdata}, 32'd0);
    prst = 1'b0;
    busy_polls = 0;
    repeat (20) step();
    chk("t6_no_done", 32'(done_cnt), 32'(d0));
    one_job(4'b0010);
    chk("t6_slot0", 32'(slot_q[slot_q.size() - 1]), 32'd0);
    chk("t6_done", 32'(last_done), 32'b0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
